uart_cmd_parser: RTL and testbench

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

---
 rtl/uart_cmd_pkg.sv | 28 ++
 rtl/sync_fifo.sv | 62 ++++++
 rtl/uart_cmd_parser.sv | 141 ++++++++++++++
 tb/tb_uart_cmd_parser.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared ASCII constants and parser state encoding
// Purpose: command characters, line terminators, digit bounds and the parser
//          state type used by uart_cmd_parser.
// Ports:   none (package).
package uart_cmd_pkg;

    localparam logic [7:0] ASCII_R_UP = 8'h52;
    localparam logic [7:0] ASCII_R_LO = 8'h72;
    localparam logic [7:0] ASCII_C_UP = 8'h43;
    localparam logic [7:0] ASCII_C_LO = 8'h63;
    localparam logic [7:0] ASCII_S_UP = 8'h53;
    localparam logic [7:0] ASCII_S_LO = 8'h73;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_NINE = 8'h39;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NUM  = 2'd1,
        ST_ERR  = 2'd2
    } parser_state_t;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_ZERO) && (b <= ASCII_NINE);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with full/empty flags
// Purpose: DEPTH-entry buffer (DEPTH a power of 2). A push while full is
//          accepted only if a pop happens in the same cycle.
// Ports:   clk, reset (sync, active-high); i_push/i_data write side;
//          i_pop read side with o_data showing the head; o_full, o_empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    // A pop frees the head slot this cycle, so a full FIFO can still take a push.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - UART command parser with byte echo
// Purpose: decodes r/R (run toggle), c/C (clear) and s/S<digits>CR (set value)
//          from received bytes, and echoes every received byte back through
//          a FIFO to the transmitter.
// Ports:   clk, reset (sync, active-high);
//          i_rx_data/i_rx_done from the receiver;
//          o_tx_start/o_tx_data/i_tx_done to/from the transmitter;
//          o_run_toggle, o_clear, o_set_valid, o_set_value to the counter;
//          o_cmd_err (malformed command), o_echo_ovf (echo byte dropped).
module uart_cmd_parser #(
    parameter int ECHO_DEPTH = 4,
    parameter int MAX_DIGITS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_done,
    input  logic        i_tx_done,
    output logic        o_tx_start,
    output logic [7:0]  o_tx_data,
    output logic        o_run_toggle,
    output logic        o_clear,
    output logic        o_set_valid,
    output logic [13:0] o_set_value,
    output logic        o_cmd_err,
    output logic        o_echo_ovf
);

    import uart_cmd_pkg::*;

    localparam int CW = $clog2(MAX_DIGITS + 1);

    parser_state_t r_state;
    logic [13:0]   r_acc;
    logic [CW-1:0] r_count;
    logic          w_is_digit;
    logic          w_digit_room;
    logic [3:0]    w_digit;

    // ASCII '0'..'9' carry their value in the low nibble.
    assign w_digit      = i_rx_data[3:0];
    assign w_is_digit   = is_digit(i_rx_data);
    assign w_digit_room = (r_count < CW'(MAX_DIGITS));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_acc        <= '0;
            r_count      <= '0;
            o_run_toggle <= 1'b0;
            o_clear      <= 1'b0;
            o_set_valid  <= 1'b0;
            o_set_value  <= '0;
            o_cmd_err    <= 1'b0;
        end else begin
            o_run_toggle <= 1'b0;
            o_clear      <= 1'b0;
            o_set_valid  <= 1'b0;
            o_cmd_err    <= 1'b0;
            if (i_rx_done) begin
                case (r_state)
                    ST_IDLE: begin
                        if (i_rx_data == ASCII_R_UP || i_rx_data == ASCII_R_LO) begin
                            o_run_toggle <= 1'b1;
                        end else if (i_rx_data == ASCII_C_UP || i_rx_data == ASCII_C_LO) begin
                            o_clear <= 1'b1;
                        end else if (i_rx_data == ASCII_S_UP || i_rx_data == ASCII_S_LO) begin
                            r_acc   <= '0;
                            r_count <= '0;
                            r_state <= ST_NUM;
                        end else if (!(i_rx_data == ASCII_CR || i_rx_data == ASCII_LF)) begin
                            o_cmd_err <= 1'b1;
                        end
                    end
                    ST_NUM: begin
                        if (w_is_digit && w_digit_room) begin
                            r_acc   <= r_acc * 14'd10 + {10'd0, w_digit};
                            r_count <= r_count + 1'b1;
                        end else if (i_rx_data == ASCII_CR && r_count != '0) begin
                            o_set_valid <= 1'b1;
                            o_set_value <= r_acc;
                            r_state     <= ST_IDLE;
                        end else begin
                            o_cmd_err <= 1'b1;
                            r_state   <= ST_ERR;
                        end
                    end
                    ST_ERR: begin
                        if (i_rx_data == ASCII_CR) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    logic       r_busy;
    logic       w_fifo_full;
    logic       w_fifo_empty;
    logic       w_pop;
    logic [7:0] w_fifo_head;

    assign w_pop = !w_fifo_empty && !r_busy;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (ECHO_DEPTH)
    ) u_echo_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (i_rx_done),
        .i_data  (i_rx_data),
        .i_pop   (w_pop),
        .o_data  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Busy is set in the pop cycle, so it is already high when o_tx_start
    // becomes visible; i_tx_done only matters while busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy     <= 1'b0;
            o_tx_start <= 1'b0;
            o_tx_data  <= 8'h00;
            o_echo_ovf <= 1'b0;
        end else begin
            o_tx_start <= w_pop;
            o_echo_ovf <= i_rx_done && w_fifo_full && !w_pop;
            if (w_pop) begin
                o_tx_data <= w_fifo_head;
                r_busy    <= 1'b1;
            end else if (i_tx_done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb/tb_uart_cmd_parser.sv - self-checking bench for uart_cmd_parser
`timescale 1ns/1ps
module tb_uart_cmd_parser;

    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;
    localparam logic [3:0] P_NONE = 4'b0000;
    localparam logic [3:0] P_RUN  = 4'b1000;
    localparam logic [3:0] P_CLR  = 4'b0100;
    localparam logic [3:0] P_SET  = 4'b0010;
    localparam logic [3:0] P_ERR  = 4'b0001;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  i_rx_data;
    logic        i_rx_done;
    logic        i_tx_done;
    logic        o_tx_start;
    logic [7:0]  o_tx_data;
    logic        o_run_toggle;
    logic        o_clear;
    logic        o_set_valid;
    logic [13:0] o_set_value;
    logic        o_cmd_err;
    logic        o_echo_ovf;

    uart_cmd_parser #(
        .ECHO_DEPTH (4),
        .MAX_DIGITS (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_rx_data    (i_rx_data),
        .i_rx_done    (i_rx_done),
        .i_tx_done    (i_tx_done),
        .o_tx_start   (o_tx_start),
        .o_tx_data    (o_tx_data),
        .o_run_toggle (o_run_toggle),
        .o_clear      (o_clear),
        .o_set_valid  (o_set_valid),
        .o_set_value  (o_set_value),
        .o_cmd_err    (o_cmd_err),
        .o_echo_ovf   (o_echo_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  b;
        logic [3:0]  pulses;
        logic [13:0] val;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] tx_exp[$];
    int         checks = 0;
    int         failures = 0;
    int         n_run = 0, n_clr = 0, n_set = 0, n_err = 0, n_ovf = 0;
    int         tx_started = 0;
    int         tx_wait = 0;
    bit         tx_pending = 0;
    bit         tx_hold = 0;
    logic [7:0] tx_cur = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [7:0] b, input logic [3:0] p, input logic [13:0] v);
        vec_t e;
        e.b = b; e.pulses = p; e.val = v;
        vecs.push_back(e);
    endtask

    // Drives one byte at a negedge; returns at the next negedge, where the
    // command pulse for that byte must be visible.
    task automatic send(input logic [7:0] b, input bit echoed);
        i_rx_data = b;
        i_rx_done = 1'b1;
        if (echoed) tx_exp.push_back(b);
        @(negedge clk);
        i_rx_done = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 400 && (tx_exp.size() != 0 || tx_pending); k++) @(negedge clk);
        check(name, 32'(tx_exp.size()), 32'd0);
        check({name, "_idle"}, 32'(tx_pending), 32'd0);
    endtask

    // Transmitter model and pulse counters.
    initial begin
        i_tx_done = 1'b0;
        forever begin
            @(negedge clk);
            i_tx_done = 1'b0;
            n_run += int'(o_run_toggle);
            n_clr += int'(o_clear);
            n_set += int'(o_set_valid);
            n_err += int'(o_cmd_err);
            n_ovf += int'(o_echo_ovf);
            if (reset) begin
                tx_pending = 0;
            end else if (o_tx_start) begin
                tx_started++;
                check("tx_start_while_busy", 32'(tx_pending), 32'd0);
                if (tx_exp.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL tx_unexpected actual=0x%0h required=none", o_tx_data);
                end else begin
                    check("tx_byte", 32'(o_tx_data), 32'(tx_exp.pop_front()));
                end
                tx_pending = 1;
                tx_cur     = o_tx_data;
                tx_wait    = 2;
            end else if (tx_pending) begin
                check("tx_data_stable", 32'(o_tx_data), 32'(tx_cur));
                if (!tx_hold) begin
                    if (tx_wait == 0) begin
                        i_tx_done  = 1'b1;
                        tx_pending = 0;
                    end else begin
                        tx_wait--;
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int exp_run, exp_clr, exp_set, exp_err, base_ovf, base_start, base_run;
        reset     = 1'b1;
        i_rx_data = 8'h00;
        i_rx_done = 1'b0;

        // S1234\r, r, C, LF, c, R
        add("S", P_NONE, 0); add("1", P_NONE, 0); add("2", P_NONE, 0);
        add("3", P_NONE, 0); add("4", P_NONE, 0); add(CR, P_SET, 1234);
        add("r", P_RUN, 1234); add("C", P_CLR, 1234); add(LF, P_NONE, 1234);
        add("c", P_CLR, 1234); add("R", P_RUN, 1234);
        // S12345\r: fifth digit errors, CR leaves ERR silently
        add("S", P_NONE, 1234); add("1", P_NONE, 1234); add("2", P_NONE, 1234);
        add("3", P_NONE, 1234); add("4", P_NONE, 1234); add("5", P_ERR, 1234);
        add(CR, P_NONE, 1234); add("r", P_RUN, 1234);
        // s7\r
        add("s", P_NONE, 1234); add("7", P_NONE, 1234); add(CR, P_SET, 7);
        // S\r errors; ERR swallows 'r' until CR; then 'x' errors in IDLE
        add("S", P_NONE, 7); add(CR, P_ERR, 7); add("r", P_NONE, 7);
        add(CR, P_NONE, 7); add("x", P_ERR, 7); add("r", P_RUN, 7);
        // S0\r and S9999\r boundaries
        add("S", P_NONE, 7); add("0", P_NONE, 7); add(CR, P_SET, 0);
        add("S", P_NONE, 0); add("9", P_NONE, 0); add("9", P_NONE, 0);
        add("9", P_NONE, 0); add("9", P_NONE, 0); add(CR, P_SET, 9999);
        // non-digit inside NUM
        add("S", P_NONE, 9999); add("1", P_NONE, 9999); add("a", P_ERR, 9999);
        add("R", P_NONE, 9999); add(CR, P_NONE, 9999); add(CR, P_NONE, 9999);

        repeat (3) @(negedge clk);
        check("rst_pulses", 32'({o_run_toggle, o_clear, o_set_valid, o_cmd_err}), 32'd0);
        check("rst_tx_start", 32'(o_tx_start), 32'd0);
        check("rst_tx_data", 32'(o_tx_data), 32'd0);
        check("rst_set_value", 32'(o_set_value), 32'd0);
        check("rst_ovf", 32'(o_echo_ovf), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        exp_run = 0; exp_clr = 0; exp_set = 0; exp_err = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            send(vecs[i].b, 1'b1);
            check($sformatf("v%0d_pulses", i),
                  32'({o_run_toggle, o_clear, o_set_valid, o_cmd_err}), 32'(vecs[i].pulses));
            check($sformatf("v%0d_set_value", i), 32'(o_set_value), 32'(vecs[i].val));
            exp_run += int'(vecs[i].pulses[3]);
            exp_clr += int'(vecs[i].pulses[2]);
            exp_set += int'(vecs[i].pulses[1]);
            exp_err += int'(vecs[i].pulses[0]);
            repeat (5) @(negedge clk);
        end
        drain("echo_drain_table");
        check("total_run", 32'(n_run), 32'(exp_run));
        check("total_clr", 32'(n_clr), 32'(exp_clr));
        check("total_set", 32'(n_set), 32'(exp_set));
        check("total_err", 32'(n_err), 32'(exp_err));
        check("total_ovf_table", 32'(n_ovf), 32'd0);

        // Six back-to-back bytes with the transmitter stalled: one in flight,
        // four queued, the sixth dropped.
        tx_hold    = 1;
        base_ovf   = n_ovf;
        base_start = tx_started;
        send("S", 1'b1);
        send("1", 1'b1);
        send("2", 1'b1);
        send("3", 1'b1);
        send("4", 1'b1);
        send("5", 1'b0);
        check("ovf_pulse", 32'(o_echo_ovf), 32'd1);
        repeat (6) @(negedge clk);
        check("ovf_count", 32'(n_ovf - base_ovf), 32'd1);
        check("in_flight", 32'(tx_started - base_start), 32'd1);
        tx_hold = 0;
        drain("echo_drain_ovf");
        check("ovf_transmitted", 32'(tx_started - base_start), 32'd5);
        send(CR, 1'b1);
        drain("echo_drain_cr");

        // Reset in the middle of "S12" with echo bytes queued; a byte arriving
        // together with reset must be neither parsed nor echoed.
        tx_hold = 1;
        send("S", 1'b1);
        send("1", 1'b1);
        send("2", 1'b1);
        base_run  = n_run;
        i_rx_data = "r";
        i_rx_done = 1'b1;
        reset     = 1'b1;
        @(negedge clk);
        i_rx_done = 1'b0;
        tx_exp.delete();
        tx_hold = 0;
        @(negedge clk);
        check("mid_rst_tx_data", 32'(o_tx_data), 32'd0);
        check("mid_rst_set_value", 32'(o_set_value), 32'd0);
        check("mid_rst_tx_start", 32'(o_tx_start), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_byte_not_parsed", 32'(n_run - base_run), 32'd0);
        check("rst_no_tx", 32'(o_tx_start), 32'd0);
        base_start = tx_started;
        send(CR, 1'b1);
        check("post_rst_cr_pulses", 32'({o_run_toggle, o_clear, o_set_valid, o_cmd_err}), 32'd0);
        drain("echo_drain_rst");
        check("post_rst_tx_count", 32'(tx_started - base_start), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
